axi4lite_regfile: RTL and testbench

//  Parametrised AXI4-Lite slave register file, successor to the fixed axi4lite FSM.

---
 rtl/axi4lite_pkg.sv | 19 +
 rtl/axi4lite_wr_ch.sv | 129 ++++++++++++
 rtl/axi4lite_regfile.sv | 145 ++++++++++++++
 tb/tb_axi4lite_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types and response codes for the AXI4-Lite register file.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4lite_wr_ch.sv
// AXI4-Lite write channel: AW/W join FSM, address/data latches and B response.
// Byte-lane masking is enabled by defining AXIL_WSTRB_EN; otherwise every write is full-word.
module axi4lite_wr_ch
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int OFS    = 2,
    parameter int IDX_W  = ADDR_W - OFS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic                err_i,
    output logic                commit_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [DATA_W-1:0]   mask_o
);

    localparam int STRB_W = DATA_W / 8;

    wr_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic [STRB_W-1:0]    strb_q;
    logic [1:0]           bresp_q;
    logic [ADDR_W-1:0]    addr_sel;
    logic [STRB_W-1:0]    strb_sel;
    logic                 aw_hs;
    logic                 w_hs;

    assign s_awready = en_i && (state_q == W_IDLE || state_q == W_HAVE_W);
    assign s_wready  = en_i && (state_q == W_IDLE || state_q == W_HAVE_AW);
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign s_bvalid  = (state_q == W_RESP);
    assign s_bresp   = bresp_q;

    // The commit may use the live channel or the latched copy, depending on which half arrived first.
    always_comb begin
        state_d  = state_q;
        commit_o = 1'b0;
        addr_sel = s_awaddr;
        data_o   = s_wdata;
        strb_sel = s_wstrb;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_o = 1'b1;
                    state_d  = W_RESP;
                end else if (aw_hs) begin
                    state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                addr_sel = addr_q;
                if (w_hs) begin
                    commit_o = 1'b1;
                    state_d  = W_RESP;
                end
            end
            W_HAVE_W: begin
                data_o   = data_q;
                strb_sel = strb_q;
                if (aw_hs) begin
                    commit_o = 1'b1;
                    state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    assign idx_o = addr_sel[ADDR_W-1:OFS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_sel[OFS-1:0];

`ifdef AXIL_WSTRB_EN
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_mask
        assign mask_o[gi*8 +: 8] = {8{strb_sel[gi]}};
    end
`else
    logic unused_strb;
    assign unused_strb = ^strb_sel;
    assign mask_o      = '1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= W_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                addr_q <= s_awaddr;
            end
            if (w_hs) begin
                data_q <= s_wdata;
                strb_q <= s_wstrb;
            end
            if (commit_o) begin
                bresp_q <= err_i ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: rtl/axi4lite_regfile.sv
// Parametrised AXI4-Lite register file: register array, read FSM and address decode.
// Define AXIL_WSTRB_EN to honour per-byte write strobes.
module axi4lite_regfile
    import axi4lite_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 32,
    parameter int                 NUM_REGS  = 16,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [DATA_W-1:0]            s_wdata,
    input  logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [ADDR_W-1:0]            s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int OFS   = $clog2(DATA_W / 8);
    localparam int IDX_W = ADDR_W - OFS;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    logic              en_q;
    logic              wr_commit;
    logic              wr_err;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_mask;

    // Readys stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    axi4lite_wr_ch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .OFS    (OFS),
        .IDX_W  (IDX_W)
    ) u_wr_ch (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en_q),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .err_i     (wr_err),
        .commit_o  (wr_commit),
        .idx_o     (wr_idx),
        .data_o    (wr_data),
        .mask_o    (wr_mask)
    );

    assign wr_err = {1'b0, wr_idx} >= NUM_REGS_L;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                reg_q <= RESET_VAL;
            end else if (wr_commit && !wr_err && wr_idx == IDX_W'(gi)) begin
                reg_q <= (reg_q & ~wr_mask) | (wr_data & wr_mask);
            end
        end
        assign regs_o[gi*DATA_W +: DATA_W] = reg_q;
    end

    rd_state_t         rd_state_q, rd_state_d;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [IDX_W-1:0]  ar_idx;
    logic              ar_err;
    logic              ar_hs;
    logic [DATA_W-1:0] rd_word;

    assign ar_idx    = s_araddr[ADDR_W-1:OFS];
    assign ar_err    = {1'b0, ar_idx} >= NUM_REGS_L;
    assign s_arready = en_q && (rd_state_q == R_IDLE);
    assign ar_hs     = s_arvalid && s_arready;
    assign s_rvalid  = (rd_state_q == R_DATA);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    logic unused_araddr_bits;
    assign unused_araddr_bits = ^s_araddr[OFS-1:0];

    // Sampling pre-edge register contents gives old-value semantics on a same-edge write.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word = regs_o[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
            R_DATA:  if (s_rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                rdata_q <= ar_err ? '0 : rd_word;
                rresp_q <= ar_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_regfile.sv
// Directed self-checking bench for axi4lite_regfile (DATA_W=32, NUM_REGS=16, RESET_VAL=0).
module tb_axi4lite_regfile;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   s_awaddr = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [31:0]  s_wdata = '0;
    logic [3:0]   s_wstrb = '0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b0;
    logic [7:0]   s_araddr = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready = 1'b0;
    logic [511:0] regs_o;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_regs [16];

    axi4lite_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .regs_o    (regs_o)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] exp_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_go = 0, w_go = 0, got = 0;
        resp = 2'b11;
        @(posedge clk); #1;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (s_awvalid && s_awready) aw_go = 1;
            if (s_wvalid && s_wready) w_go = 1;
            if (s_bvalid) begin resp = s_bresp; got = 1; end
            @(posedge clk); #1;
            if (aw_go) s_awvalid = 1'b0;
            if (w_go) s_wvalid = 1'b0;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        checks++;
        if (!got) $display("FAIL write_timeout addr=%h: no B response seen, required one", a);
        else passes++;
        $display("write addr=%h data=%h strb=%b resp=%b", a, d, s, resp);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_go = 0, got = 0;
        d = 'x; resp = 2'b11;
        @(posedge clk); #1;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (s_arvalid && s_arready) ar_go = 1;
            if (s_rvalid) begin d = s_rdata; resp = s_rresp; got = 1; end
            @(posedge clk); #1;
            if (ar_go) s_arvalid = 1'b0;
        end
        s_arvalid = 1'b0; s_rready = 1'b0;
        checks++;
        if (!got) $display("FAIL read_timeout addr=%h: no R response seen, required one", a);
        else passes++;
        $display("read  addr=%h data=%h resp=%b", a, d, resp);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0)
            $display("FAIL reset_hold: ready/valid=%b, required 00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000)
            $display("FAIL ready_before_edge: readys=%b, required 000", {s_awready, s_wready, s_arready});
        else passes++;
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100)
            $display("FAIL ready_after_edge: ready/valid=%b, required 11100",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        else passes++;
        checks++;
        if (regs_o !== 512'd0 || s_rdata !== 32'd0 || s_bresp !== 2'b00 || s_rresp !== 2'b00)
            $display("FAIL reset_values: regs_o nonzero=%b rdata=%h bresp=%b rresp=%b, required all zero",
                     |regs_o, s_rdata, s_bresp, s_rresp);
        else passes++;
        $display("reset released");
    endtask

    task automatic test_simul_write();
        logic [31:0] d;
        logic [1:0]  r;
        @(posedge clk); #1;
        s_awaddr = 8'h08; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b0) $display("FAIL b_before_commit: bvalid=%b, required 0", s_bvalid);
        else passes++;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        exp_regs[2] = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00)
            $display("FAIL simul_b: bvalid=%b bresp=%b, required 1 00", s_bvalid, s_bresp);
        else passes++;
        checks++;
        if (regs_o !== exp_flat()) $display("FAIL simul_regs: reg2=%h, required deadbeef", regs_o[64 +: 32]);
        else passes++;
        @(posedge clk); #1;
        s_bready = 1'b0;
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b0) $display("FAIL simul_b_done: bvalid=%b, required 0", s_bvalid);
        else passes++;
        axi_read(8'h08, d, r);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 2'b00)
            $display("FAIL simul_read: rdata=%h rresp=%b, required deadbeef 00", d, r);
        else passes++;
    endtask

    task automatic test_w_before_aw();
        bit stable = 1, seen = 0;
        @(posedge clk); #1;
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_bvalid, s_wready, s_awready} !== 3'b001)
            $display("FAIL have_w: bvalid/wready/awready=%b, required 001", {s_bvalid, s_wready, s_awready});
        else passes++;
        @(posedge clk); #1;
        s_awaddr = 8'h04; s_awvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        exp_regs[1] = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(s_bvalid === 1'b1 && s_bresp === 2'b00 && s_awready === 1'b0 && s_wready === 1'b0))
                stable = 0;
            @(posedge clk); #1;
        end
        checks++;
        if (!stable) $display("FAIL b_hold: bvalid=%b bresp=%b awready=%b, required 1 00 0 throughout",
                              s_bvalid, s_bresp, s_awready);
        else passes++;
        checks++;
        if (regs_o !== exp_flat()) $display("FAIL w_first_regs: reg1=%h, required 12345678", regs_o[32 +: 32]);
        else passes++;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_bvalid) seen = 1;
        end
        checks++;
        if (seen || s_awready !== 1'b1)
            $display("FAIL single_b: extra bvalid=%b awready=%b, required 0 1", seen, s_awready);
        else passes++;
        $display("write w-before-aw addr=04 data=12345678 done");
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h40, 32'h55555555, 4'hF, r);
        checks++;
        if (r !== 2'b10) $display("FAIL slverr_bresp: bresp=%b, required 10", r);
        else passes++;
        checks++;
        if (regs_o !== exp_flat()) $display("FAIL slverr_regs: register array changed on out-of-range write");
        else passes++;
        axi_read(8'h40, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b10) $display("FAIL slverr_read: rdata=%h rresp=%b, required 0 10", d, r);
        else passes++;
        axi_write(8'h3F, 32'h0F0F0F0F, 4'hF, r);
        exp_regs[15] = 32'h0F0F0F0F;
        checks++;
        if (r !== 2'b00) $display("FAIL top_index_bresp: bresp=%b, required 00", r);
        else passes++;
        axi_read(8'h3C, d, r);
        checks++;
        if (d !== 32'h0F0F0F0F || r !== 2'b00)
            $display("FAIL top_index_read: rdata=%h rresp=%b, required 0f0f0f0f 00", d, r);
        else passes++;
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h08, 32'hFFFFFFFF, 4'hF, r);
        axi_write(8'h08, 32'h00000000, 4'b0101, r);
`ifdef AXIL_WSTRB_EN
        exp_regs[2] = 32'hFF00FF00;
`else
        exp_regs[2] = 32'h00000000;
`endif
        axi_read(8'h08, d, r);
        checks++;
        if (d !== exp_regs[2] || r !== 2'b00)
            $display("FAIL wstrb_read: rdata=%h rresp=%b, required %h 00", d, r, exp_regs[2]);
        else passes++;
    endtask

    task automatic test_read_write_collision();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h0C, 32'h0000000A, 4'hF, r);
        @(posedge clk); #1;
        s_araddr = 8'h0C; s_arvalid = 1'b1; s_rready = 1'b1;
        s_awaddr = 8'h0C; s_wdata = 32'h0000000B; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        exp_regs[3] = 32'h0000000B;
        @(negedge clk);
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h0000000A || s_bvalid !== 1'b1)
            $display("FAIL collide_old: rvalid=%b rdata=%h bvalid=%b, required 1 0000000a 1",
                     s_rvalid, s_rdata, s_bvalid);
        else passes++;
        checks++;
        if (regs_o !== exp_flat()) $display("FAIL collide_regs: reg3=%h, required 0000000b", regs_o[96 +: 32]);
        else passes++;
        @(posedge clk); #1;
        s_rready = 1'b0; s_bready = 1'b0;
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'h0000000B) $display("FAIL collide_new: rdata=%h, required 0000000b", d);
        else passes++;
    endtask

    task automatic test_reset_mid_b();
        bit seen = 0;
        @(posedge clk); #1;
        s_awaddr = 8'h10; s_wdata = 32'h77; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b1) $display("FAIL mid_b_pending: bvalid=%b, required 1", s_bvalid);
        else passes++;
        #2 reset = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        #1;
        checks++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b0 || regs_o !== exp_flat())
            $display("FAIL async_reset: bvalid=%b awready=%b regs nonzero=%b, required 0 0 0",
                     s_bvalid, s_awready, |regs_o);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1; s_bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_bvalid) seen = 1;
        end
        s_bready = 1'b0;
        checks++;
        if (seen || s_awready !== 1'b1)
            $display("FAIL no_b_after_reset: bvalid seen=%b awready=%b, required 0 1", seen, s_awready);
        else passes++;
        $display("reset during B phase done");
    endtask

    initial begin
        test_reset();
        test_simul_write();
        test_w_before_aw();
        test_slverr();
        test_wstrb();
        test_read_write_collision();
        test_reset_mid_b();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
